// File: rtl/pio_start_pkg.sv
// Shared types and register-map constants for the pio_start_ctrl slice.
package pio_start_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_CTRL = 2'd1;
    localparam logic [1:0] ADDR_STAT = 2'd2;
    localparam logic [1:0] ADDR_CYC  = 2'd3;

    localparam int CTRL_START = 0;
    localparam int CTRL_ABORT = 1;
    localparam int STAT_BUSY  = 0;
    localparam int STAT_DONE  = 1;
    localparam int STAT_OVR   = 2;

    function automatic logic [31:0] status_word(input logic busy_i,
                                                input logic done_i,
                                                input logic ovr_i);
        return {29'd0, ovr_i, done_i, busy_i};
    endfunction

endpackage

// File: rtl/pio_start_fsm.sv
// Start/done handshake sequencer: pulse timer, done_in rising-edge detect and
// saturating busy-cycle counter.
module pio_start_fsm
    import pio_start_pkg::*;
#(
    parameter int PULSE_LEN = 4,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_cmd,
    input  logic             abort_cmd,
    input  logic             done_in,
    output logic             start_out,
    output logic             busy,
    output logic [CNT_W-1:0] cycles,
    output logic             start_acc,
    output logic             done_set,
    output logic             ovr_set
);

    localparam int PW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(PULSE_LEN - 1);

    state_e           state_q, state_d;
    logic [PW-1:0]    pcnt_q, pcnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             done_q, rise;
    logic             start_q, start_d;
    logic             busy_q, busy_d;

    assign rise    = done_in & ~done_q;
    assign cnt_inc = (cnt_q != {CNT_W{1'b1}}) ? cnt_q + CNT_W'(1) : cnt_q;

    // Next state: abort overrides everything; the counter does not tick on
    // the done edge itself, so it freezes at the number of busy cycles.
    always_comb begin
        state_d   = state_q;
        pcnt_d    = pcnt_q;
        cnt_d     = cnt_q;
        start_acc = 1'b0;
        done_set  = 1'b0;
        ovr_set   = 1'b0;
        if (abort_cmd) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start_cmd) begin
                        state_d   = PULSE;
                        pcnt_d    = '0;
                        cnt_d     = '0;
                        start_acc = 1'b1;
                    end else begin
                        state_d = state_q;
                    end
                end
                PULSE: begin
                    cnt_d   = cnt_inc;
                    ovr_set = start_cmd;
                    if (pcnt_q == P_LAST) begin
                        state_d = WAIT;
                        pcnt_d  = '0;
                    end else begin
                        pcnt_d = pcnt_q + PW'(1);
                    end
                end
                WAIT: begin
                    ovr_set = start_cmd;
                    if (rise) begin
                        state_d  = DONE;
                        done_set = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        start_d = (state_d == PULSE);
        busy_d  = (state_d == PULSE) || (state_d == WAIT);
    end

    // State, timers and registered handshake outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pcnt_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pcnt_q  <= pcnt_d;
            cnt_q   <= cnt_d;
            done_q  <= done_in;
            start_q <= start_d;
            busy_q  <= busy_d;
        end
    end

    assign start_out = start_q;
    assign busy      = busy_q;
    assign cycles    = cnt_q;

endmodule

// File: rtl/pio_start_ctrl.sv
// Avalon-MM control PIO for the compute-start handshake: register file and read mux.
// Optional interrupt output and mask register enabled by PIO_START_IRQ_EN.
module pio_start_ctrl
    import pio_start_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int PULSE_LEN = 4,
    parameter int CNT_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [DATA_W-1:0] out_port,
    output logic              start_out,
    input  logic              done_in,
`ifdef PIO_START_IRQ_EN
    output logic              irq,
`endif
    output logic              busy
);

    logic              wr_en, start_cmd, abort_cmd, w1c;
    logic              start_acc, done_set, ovr_set;
    logic [CNT_W-1:0]  cycles;
    logic [DATA_W-1:0] data_q, data_d;
    logic              done_stk_q, done_stk_d;
    logic              ovr_stk_q, ovr_stk_d;
    logic [31:0]       readdata_q, readdata_d;

    assign wr_en     = chipselect & ~write_n;
    assign start_cmd = wr_en && (address == ADDR_CTRL) && writedata[CTRL_START];
    assign abort_cmd = wr_en && (address == ADDR_CTRL) && writedata[CTRL_ABORT];
    assign w1c       = wr_en && (address == ADDR_STAT);

    pio_start_fsm #(
        .PULSE_LEN (PULSE_LEN),
        .CNT_W     (CNT_W)
    ) u_fsm (
        .clk       (clk),
        .reset     (reset),
        .start_cmd (start_cmd),
        .abort_cmd (abort_cmd),
        .done_in   (done_in),
        .start_out (start_out),
        .busy      (busy),
        .cycles    (cycles),
        .start_acc (start_acc),
        .done_set  (done_set),
        .ovr_set   (ovr_set)
    );

    // Register updates; a set event takes priority over a same-cycle W1C.
    always_comb begin
        data_d = data_q;
        if (wr_en && (address == ADDR_DATA)) begin
            data_d = writedata[DATA_W-1:0];
        end else begin
            data_d = data_q;
        end

        done_stk_d = done_stk_q;
        if (done_set) begin
            done_stk_d = 1'b1;
        end else if (start_acc || (w1c && writedata[STAT_DONE])) begin
            done_stk_d = 1'b0;
        end else begin
            done_stk_d = done_stk_q;
        end

        ovr_stk_d = ovr_stk_q;
        if (ovr_set) begin
            ovr_stk_d = 1'b1;
        end else if (w1c && writedata[STAT_OVR]) begin
            ovr_stk_d = 1'b0;
        end else begin
            ovr_stk_d = ovr_stk_q;
        end

        readdata_d = 32'd0;
        case (address)
            ADDR_DATA: readdata_d = 32'(data_q);
            ADDR_CTRL: readdata_d = 32'd0;
            ADDR_STAT: readdata_d = status_word(busy, done_stk_q, ovr_stk_q);
            ADDR_CYC:  readdata_d = 32'(cycles);
            default:   readdata_d = 32'd0;
        endcase
    end

    // Register file and read-data pipeline stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q     <= '0;
            done_stk_q <= 1'b0;
            ovr_stk_q  <= 1'b0;
            readdata_q <= 32'd0;
        end else begin
            data_q     <= data_d;
            done_stk_q <= done_stk_d;
            ovr_stk_q  <= ovr_stk_d;
            readdata_q <= readdata_d;
        end
    end

    assign out_port = data_q;
    assign readdata = readdata_q;

`ifdef PIO_START_IRQ_EN
    logic [1:0] mask_q, mask_d;
    logic       irq_q, irq_d;

    // Mask shares address 3 with the read-only cycle counter.
    always_comb begin
        mask_d = mask_q;
        if (wr_en && (address == ADDR_CYC)) begin
            mask_d = writedata[1:0];
        end else begin
            mask_d = mask_q;
        end
        irq_d = |(mask_q & {ovr_stk_q, done_stk_q});
    end

    // Registered interrupt request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_q <= 2'd0;
            irq_q  <= 1'b0;
        end else begin
            mask_q <= mask_d;
            irq_q  <= irq_d;
        end
    end

    assign irq = irq_q;
`endif

endmodule

// File: tb/tb_pio_start_ctrl.sv
// Directed self-checking bench for pio_start_ctrl (DATA_W=32, PULSE_LEN=4, CNT_W=32).
module tb_pio_start_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [31:0] out_port;
    logic        start_out;
    logic        done_in;
    logic        busy;
`ifdef PIO_START_IRQ_EN
    logic        irq;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    int hi_cnt;

    always #5 clk = ~clk;

    pio_start_ctrl #(
        .DATA_W    (32),
        .PULSE_LEN (4),
        .CNT_W     (32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port),
        .start_out  (start_out),
        .done_in    (done_in),
`ifdef PIO_START_IRQ_EN
        .irq        (irq),
`endif
        .busy       (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        tick();
        chipselect = 1'b0;
        chk(tag, readdata, exp);
    endtask

    initial begin
        reset      = 1'b1;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;
        done_in    = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Reset state
        chk("rst_start_out", {31'd0, start_out}, 32'd0);
        chk("rst_out_port", out_port, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rd(2'd0, 32'd0, "rst_rd_data");
        rd(2'd1, 32'd0, "rst_rd_ctrl");
        rd(2'd2, 32'd0, "rst_rd_stat");
        rd(2'd3, 32'd0, "rst_rd_cyc");

        // DATA register
        wr(2'd0, 32'hA5A5_0001);
        chk("data_out_port", out_port, 32'hA5A5_0001);
        rd(2'd0, 32'hA5A5_0001, "data_rd");

        // Start: pulse is 4 cycles; done rises 10 cycles after pulse ends
        wr(2'd1, 32'h1);
        hi_cnt = 0;
        while (start_out === 1'b1 && hi_cnt < 20) begin
            hi_cnt++;
            tick();
        end
        chk("pulse_len", 32'(hi_cnt), 32'd4);
        chk("busy_in_wait", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 10; i++) tick();
        done_in = 1'b1;
        tick();
        done_in = 1'b0;
        chk("busy_after_done", {31'd0, busy}, 32'd0);
        rd(2'd2, 32'h2, "stat_done");
        rd(2'd3, 32'd14, "cycles_14");

        // Start from DONE clears done_sticky; start in WAIT sets overrun
        wr(2'd1, 32'h1);
        rd(2'd2, 32'h1, "stat_restart");
        for (int i = 0; i < 5; i++) tick();
        wr(2'd1, 32'h1);
        chk("no_extra_pulse", {31'd0, start_out}, 32'd0);
        rd(2'd2, 32'h5, "stat_overrun");
        wr(2'd2, 32'h4);
        rd(2'd2, 32'h1, "w1c_overrun");
        done_in = 1'b1;
        wr(2'd2, 32'h2);
        done_in = 1'b0;
        rd(2'd2, 32'h2, "set_beats_w1c");

        // done_in high before start: needs a fresh rising edge
        done_in = 1'b1;
        tick();
        wr(2'd1, 32'h1);
        for (int i = 0; i < 10; i++) tick();
        chk("level_no_done_busy", {31'd0, busy}, 32'd1);
        rd(2'd2, 32'h1, "level_no_done_stat");
        done_in = 1'b0;
        tick();
        done_in = 1'b1;
        tick();
        done_in = 1'b0;
        rd(2'd2, 32'h2, "edge_done_stat");

        // Abort in WAIT: counter frozen at 6 (4 pulse + 2 wait cycles)
        wr(2'd1, 32'h1);
        for (int i = 0; i < 6; i++) tick();
        wr(2'd1, 32'h2);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_start_out", {31'd0, start_out}, 32'd0);
        rd(2'd2, 32'h0, "abort_stat");
        rd(2'd3, 32'd6, "abort_cycles");
        tick();
        rd(2'd3, 32'd6, "abort_cycles_frozen");

        // Start and abort together: abort wins
        wr(2'd1, 32'h3);
        chk("start_abort_busy", {31'd0, busy}, 32'd0);
        chk("start_abort_pulse", {31'd0, start_out}, 32'd0);

        // DATA write while busy; CONTROL reads back as 0
        wr(2'd1, 32'h1);
        wr(2'd0, 32'h1234_5678);
        chk("data_while_busy", out_port, 32'h1234_5678);
        rd(2'd1, 32'd0, "ctrl_reads_zero");
        wr(2'd1, 32'h2);

        // Reset during pulse cycle 2 drops start_out asynchronously
        wr(2'd1, 32'h1);
        tick();
        chk("pulse_cycle2", {31'd0, start_out}, 32'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("async_rst_start", {31'd0, start_out}, 32'd0);
        chk("async_rst_busy", {31'd0, busy}, 32'd0);
        chk("async_rst_data", out_port, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        rd(2'd2, 32'd0, "post_rst_stat");
        rd(2'd3, 32'd0, "post_rst_cyc");

`ifdef PIO_START_IRQ_EN
        // Interrupt on done; W1C clears irq one cycle later
        wr(2'd3, 32'h1);
        wr(2'd1, 32'h1);
        for (int i = 0; i < 5; i++) tick();
        done_in = 1'b1;
        tick();
        done_in = 1'b0;
        tick();
        chk("irq_set", {31'd0, irq}, 32'd1);
        wr(2'd2, 32'h2);
        chk("irq_hold", {31'd0, irq}, 32'd1);
        tick();
        chk("irq_clear", {31'd0, irq}, 32'd0);
`else
        // Address 3 writes have no effect without the interrupt option
        wr(2'd3, 32'hFFFF_FFFF);
        rd(2'd3, 32'd0, "cyc_write_ignored");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
